// File: rtl/wishbone_slave_ram.sv
// wishbone_slave_ram: Wishbone classic slave with a byte RAM window at BASE, wait states and ack/err/rty terminations
// Ports: clk_i/rst_i clock and sync active-high reset; cyc_i/stb_i/we_i/adr_i/dat_i request;
//        dat_o read data; ack_o/err_o/rty_o registered terminations; lock_i refuses in-window accesses with retry.
module wishbone_slave_ram #(
    parameter int          AW          = 8,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [7:0]  dat_i,
    output logic [7:0]  dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    input  logic        lock_i
);
    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  WAIT = 2'd1;
    localparam logic [1:0]  RESP = 2'd2;
    localparam logic [16:0] SIZE = 17'd1 << AW;
    logic [1:0]  state, nxt;
    logic [3:0]  cnt;
    logic [15:0] adr_q, adr_c, off;
    logic        we_q, we_c, req, fin, in_win, go;
    logic [7:0]  dat_q, dat_c;
    logic [7:0]  mem [0:(1<<AW)-1];
    // In IDLE the live bus is used so zero-wait accesses terminate off the request edge itself.
    always_comb begin
        req    = cyc_i & stb_i;
        adr_c  = (state == IDLE) ? adr_i : adr_q;
        we_c   = (state == IDLE) ? we_i : we_q;
        dat_c  = (state == IDLE) ? dat_i : dat_q;
        off    = adr_c - BASE;
        in_win = (adr_c >= BASE) && ({1'b0, off} < SIZE);
        fin    = req && ((state == IDLE && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0));
        go     = fin && in_win && !lock_i;
        nxt    = fin ? RESP : (req && state != RESP) ? WAIT : IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            rty_o <= 1'b0;
            dat_o <= 8'h00;
        end else begin
            state <= nxt;
            cnt   <= (nxt == WAIT) ? ((state == IDLE) ? 4'(WAIT_STATES - 1) : cnt - 4'd1) : 4'd0;
            ack_o <= go;
            err_o <= fin && !in_win;
            rty_o <= fin && in_win && lock_i;
            if (go && !we_c) dat_o <= mem[off[AW-1:0]];
        end
    end
    always_ff @(posedge clk_i) begin
        if (state == IDLE && req) begin
            adr_q <= adr_i;
            we_q  <= we_i;
            dat_q <= dat_i;
        end
    end
    // RAM has no reset; a reset edge only suppresses the commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && go && we_c) mem[off[AW-1:0]] <= dat_c;
    end
endmodule

// File: doc/wishbone_slave_ram.md
# wishbone_slave_ram

Wishbone classic-cycle slave with an 8-bit data bus and 16-bit address bus: the responder end of the team's Wishbone master. It holds a byte-wide RAM window of 2^AW locations mapped at address BASE. Accesses take a programmable number of wait states. The slave terminates every accepted cycle with exactly one of ack, err or rty, and it is the target used to exercise the master's full termination handling.

## Interface
Parameters:
- AW, 8: RAM address width; window size is 2^AW bytes (1..15).
- BASE, 16'h0000: first bus address of the window; BASE + 2^AW must be ≤ 65536.
- WAIT_STATES, 0: extra cycles inserted before the termination (0..15).

Ports:
- clk_i  in  1  single system clock; everything is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe; a transfer is requested when cyc_i & stb_i.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  16  byte address.
- dat_i  in  8  write data.
- dat_o  out  8  read data; valid in the ack cycle of a read.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination (address outside the window).
- rty_o  out  1  retry termination (lock_i high).
- lock_i  in  1  local lock; when high, in-window accesses are refused with retry.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if cyc_i & stb_i is sampled high, latch adr_i, we_i and dat_i. Go to WAIT if WAIT_STATES > 0, else compute the termination and go to RESP.
- WAIT: a counter loads WAIT_STATES-1 on entry and decrements each cycle. When the counter reaches 0, compute the termination and go to RESP.
- WAIT abort: if cyc_i or stb_i is low in any WAIT cycle, return to IDLE immediately. No write, no termination.
- RESP: exactly one of ack_o, err_o or rty_o is high for this single cycle. Then go to IDLE unconditionally.
- Range check: offset = adr − BASE in 16-bit unsigned arithmetic. The address is in-window when adr ≥ BASE and offset < 2^AW. RAM index = offset[AW-1:0].
- Termination priority, evaluated at the edge entering RESP:
  - Out-of-window gives err.
  - Otherwise lock_i high gives rty.
  - Otherwise ack.
- Write with ack: mem[index] ← latched dat_i at the edge entering RESP. err and rty never write.
- Read with ack: dat_o ← mem[index] at the edge entering RESP. dat_o holds its value at all other times, including err and rty.
- RAM contents are not initialised and are not cleared by reset.
- Back-to-back transfers: the cycle after RESP is IDLE, so a request held or presented then is treated as a new transfer.

## Timing
- Reset values: ack_o = err_o = rty_o = 0, dat_o = 8'h00, state IDLE, wait counter 0.
- Latency: request first sampled at edge n, termination visible in cycle n+1+WAIT_STATES.
- Maximum throughput: one transfer per 2+WAIT_STATES cycles.
- Terminations are registered outputs, never combinational from the inputs.
- At most one of ack_o, err_o or rty_o is high in any cycle, and each is high for exactly one cycle.
- Signal changes during WAIT:
  - Changes to adr_i, we_i and dat_i are ignored (values are latched in IDLE).
  - lock_i is sampled only at the edge entering RESP.
- Reset asserted mid-transfer (WAIT or RESP): the next edge forces all outputs to their reset values and the state to IDLE. A write not yet committed is dropped.
- Address boundaries: BASE and BASE + 2^AW − 1 are in-window. BASE − 1 (when BASE > 0) and BASE + 2^AW are out-of-window.

## Test plan
- Write then read, WAIT_STATES = 0, BASE = 16'h1000:
  - Write 8'hA5 to 16'h1003 → ack_o high exactly one cycle after the request edge.
  - Read 16'h1003 → dat_o = 8'hA5 with ack_o.
- WAIT_STATES = 3: read request at edge n → ack_o in cycle n+4. err_o and rty_o stay low throughout.
- Range edges, AW = 8, BASE = 16'h1000:
  - 16'h10FF → ack_o.
  - 16'h1100 → err_o.
  - 16'h0FFF → err_o.
  - An err write does not change mem.
- lock_i = 1 on an in-window write of 8'h3C → rty_o. A later read of the same address returns the old value.
- Abort and reset, WAIT_STATES = 3:
  - stb_i dropped in the second WAIT cycle → no termination, no write, state IDLE.
  - rst_i asserted during WAIT → all outputs 0 on the next cycle, and the pending write is lost.
